// File: rtl/gm_pkg.sv
// Shared constants for the stone sprite drawer: RAM word layout, type colours, screen limits.
// Latency: n/a (types, constants and a pure colour lookup only).
// Backpressure: n/a.
package gm_pkg;

    // Stone-RAM word field positions
    localparam int X_MSB    = 31;
    localparam int X_LSB    = 23;
    localparam int Y_MSB    = 18;
    localparam int Y_LSB    = 11;
    localparam int TYPE_MSB = 3;
    localparam int TYPE_LSB = 2;
    localparam int VIS_BIT  = 1;
    localparam int MOVE_BIT = 0;

    // Stone type codes
    localparam logic [1:0] TYPE_0 = 2'b00;
    localparam logic [1:0] TYPE_1 = 2'b01;
    localparam logic [1:0] TYPE_2 = 2'b10;
    localparam logic [1:0] TYPE_3 = 2'b11;

    // Pixel colours
    localparam logic [2:0] COL_ERASE = 3'b000;
    localparam logic [2:0] COL_TYPE0 = 3'b111;
    localparam logic [2:0] COL_TYPE1 = 3'b110;
    localparam logic [2:0] COL_TYPE2 = 3'b011;

    // Visible screen and default sprite edge
    localparam int SCREEN_W    = 320;
    localparam int SCREEN_H    = 240;
    localparam int DEFAULT_BOX = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        READ_WAIT = 3'd2,
        LATCH     = 3'd3,
        ERASE     = 3'd4,
        DRAW      = 3'd5,
        NEXT      = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Types 2 and 3 share one colour
    function automatic logic [2:0] type_colour(input logic [1:0] t);
        case (t)
            TYPE_0:  return COL_TYPE0;
            TYPE_1:  return COL_TYPE1;
            TYPE_2:  return COL_TYPE2;
            default: return COL_TYPE2;
        endcase
    endfunction

endpackage

// File: rtl/box_scanner.sv
// Walks a BOX x BOX square row-major from a base point, one pixel per cycle, with screen clipping.
// Latency: pixel (x, y, colour, plot) registered one cycle after its dx/dy counter value.
// Backpressure: none; the scan always runs to completion and clipped pixels still take their cycle.
module box_scanner
    import gm_pkg::*;
#(
    parameter int BOX = DEFAULT_BOX
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [8:0] base_x,
    input  logic [7:0] base_y,
    input  logic [2:0] shade,
    output logic       busy,
    output logic       last,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int            CW   = $clog2(BOX + 1);
    localparam logic [CW-1:0] EDGE = CW'(BOX - 1);

    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [8:0]    bx;
    logic [7:0]    by;
    logic [2:0]    sh;
    logic [9:0]    px;
    logic [8:0]    py;
    logic          on_screen;

    // One extra bit so a sum past the coordinate range reads as off-screen instead of wrapping
    assign px        = {1'b0, bx} + 10'(dx);
    assign py        = {1'b0, by} + 9'(dy);
    assign on_screen = (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
    assign last      = busy && (dx == EDGE) && (dy == EDGE);

    // Scan counters: dx runs fastest, the scan ends after the bottom-right pixel
    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy <= 1'b0;
            dx   <= '0;
            dy   <= '0;
            bx   <= '0;
            by   <= '0;
            sh   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            dx   <= '0;
            dy   <= '0;
            bx   <= base_x;
            by   <= base_y;
            sh   <= shade;
        end else if (busy) begin
            if (dx == EDGE) begin
                dx <= '0;
                if (dy == EDGE) begin
                    busy <= 1'b0;
                end else begin
                    dy <= dy + 1'b1;
                end
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    // Registered pixel port; plot only for on-screen pixels of an active scan
    always_ff @(posedge clock) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot <= busy && on_screen;
            if (busy) begin
                x      <= px[8:0];
                y      <= py[7:0];
                colour <= sh;
            end
        end
    end

endmodule

// File: rtl/stone_drawer.sv
// Periodically walks the stone RAM, erasing stale sprites and drawing visible ones as pixel writes.
// Latency: pass every FRAME_CLOCK cycles; RAM word latched two cycles after the address is set.
// Backpressure: none on pixels; draw_stone_flag stalls the rope controller's RAM access while a pass runs.
module stone_drawer
    import gm_pkg::*;
#(
    parameter int FRAME_CLOCK = 833_334,
    parameter int BOX         = DEFAULT_BOX
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic [3:0]  quantity,
    input  logic [31:0] data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        pass_done
);

    localparam int FW = $clog2(FRAME_CLOCK + 1);

    logic [FW-1:0] frame_cnt;
    logic          start_pass;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    index;

    // Last-drawn position per RAM entry, in flops so LATCH can decide in the same cycle
    logic [8:0]    shadow_x [16];
    logic [7:0]    shadow_y [16];
    logic [15:0]   drawn;

    logic [8:0]    new_x;
    logic [7:0]    new_y;
    logic [1:0]    new_type;
    logic          new_vis;

    logic [8:0]    data_x;
    logic [7:0]    data_y;
    logic [1:0]    data_type;
    logic          data_vis;
    logic          idx_over;
    logic          need_erase;

    logic          scan_start;
    logic [8:0]    scan_x;
    logic [7:0]    scan_y;
    logic [2:0]    scan_shade;
    logic          scan_busy;
    logic          scan_last;
    logic          scan_end;
    logic          unused_bits;

    assign data_x      = data[X_MSB:X_LSB];
    assign data_y      = data[Y_MSB:Y_LSB];
    assign data_type   = data[TYPE_MSB:TYPE_LSB];
    assign data_vis    = data[VIS_BIT];
    assign unused_bits = ^{data[22:19], data[10:4], data[MOVE_BIT]};

    assign start_pass  = enable && (frame_cnt >= FW'(FRAME_CLOCK - 1));
    assign idx_over    = index >= {1'b0, quantity};
    assign need_erase  = drawn[index[3:0]] &&
                         (!data_vis || (data_x != shadow_x[index[3:0]]) ||
                          (data_y != shadow_y[index[3:0]]));
    // A scan that is no longer busy also counts as finished, so the FSM can never wait forever
    assign scan_end    = scan_last || !scan_busy;

    // Frame pacing: free-running while enabled, restarts on every start request even mid-pass
    always_ff @(posedge clock) begin
        if (!resetn || !enable) begin
            frame_cnt <= '0;
        end else if (start_pass) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start requests outside IDLE are simply dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_pass) state_nxt = READ;
            READ:      state_nxt = READ_WAIT;
            READ_WAIT: state_nxt = LATCH;
            LATCH: begin
                if (idx_over)        state_nxt = DONE;
                else if (need_erase) state_nxt = ERASE;
                else if (data_vis)   state_nxt = DRAW;
                else                 state_nxt = NEXT;
            end
            ERASE:     if (scan_end) state_nxt = new_vis ? DRAW : NEXT;
            DRAW:      if (scan_end) state_nxt = NEXT;
            NEXT:      state_nxt = (index == 5'd15) ? DONE : READ;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Scanner launch: erase at the old spot first, then draw straight after at the new one
    always_comb begin
        scan_start = 1'b0;
        scan_x     = new_x;
        scan_y     = new_y;
        scan_shade = type_colour(new_type);
        case (state)
            LATCH: begin
                if (!idx_over && need_erase) begin
                    scan_start = 1'b1;
                    scan_x     = shadow_x[index[3:0]];
                    scan_y     = shadow_y[index[3:0]];
                    scan_shade = COL_ERASE;
                end else if (!idx_over && data_vis) begin
                    scan_start = 1'b1;
                    scan_x     = data_x;
                    scan_y     = data_y;
                    scan_shade = type_colour(data_type);
                end
            end
            ERASE:   scan_start = scan_end && new_vis;
            default: scan_start = 1'b0;
        endcase
    end

    // Pass bookkeeping: index walk, RAM address, latched entry, drawn bits and status flags
    always_ff @(posedge clock) begin
        if (!resetn) begin
            index           <= '0;
            draw_index      <= '0;
            drawn           <= '0;
            new_x           <= '0;
            new_y           <= '0;
            new_type        <= '0;
            new_vis         <= 1'b0;
            draw_stone_flag <= 1'b0;
            pass_done       <= 1'b0;
        end else begin
            draw_stone_flag <= (state_nxt != IDLE);
            pass_done       <= (state_nxt == DONE);
            if (state == IDLE) begin
                index <= '0;
            end
            if (state == READ) begin
                draw_index <= index[3:0];
            end
            if (state == LATCH) begin
                new_x    <= data_x;
                new_y    <= data_y;
                new_type <= data_type;
                new_vis  <= data_vis;
            end
            if (state == NEXT) begin
                drawn[index[3:0]] <= new_vis;
                index             <= index + 1'b1;
            end
        end
    end

    // Shadow positions need no reset: they are only consulted when the drawn bit is set
    always_ff @(posedge clock) begin
        if (resetn && (state == NEXT)) begin
            shadow_x[index[3:0]] <= new_x;
            shadow_y[index[3:0]] <= new_y;
        end
    end

    box_scanner #(
        .BOX(BOX)
    ) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .start  (scan_start),
        .base_x (scan_x),
        .base_y (scan_y),
        .shade  (scan_shade),
        .busy   (scan_busy),
        .last   (scan_last),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

endmodule
